tdc_therm_decoder: RTL and testbench

TDC_THERM_DECODER -- requirements
Module: tdc_therm_decoder

---
 rtl/tdc_therm_decoder.sv | 159 +++++++++++++++
 tb/tb_tdc_therm_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_therm_decoder.sv
// Carry-chain TDC thermometer-to-binary decoder: bubble-tolerant zero count in three
// registered stages with valid/ready flow control. Define TDC_AVG_EN to average batches of 2^AVG_LOG2 results.
module tdc_therm_decoder #(
    parameter int CHAIN_LEN = 200,
    parameter int OUT_W     = 8,
    parameter int AVG_LOG2  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [CHAIN_LEN-1:0] in_code,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_fine,
    output logic                 out_ovf
);

    localparam int NBITS = CHAIN_LEN - 1;
    localparam int GROUP = 20;
    localparam int NG    = (NBITS + GROUP - 1) / GROUP;
    localparam int GW    = $clog2(GROUP + 1);

    if ((1 << OUT_W) <= CHAIN_LEN || AVG_LOG2 < 1) begin : g_param_check
        $error("tdc_therm_decoder: OUT_W too narrow for CHAIN_LEN or AVG_LOG2 < 1");
    end

    // Handshake: a word moves on in_valid && in_ready, a result on out_valid && out_ready.
    // Every stage advances together on adv, so a held output freezes the whole pipe.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || !rstn;

    // S1: capture and invert so that propagated (zero) taps become ones.
    logic             s1_valid;
    logic             s1_ovf;
    logic [NBITS-1:0] s1_inv;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_inv   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_ovf   <= in_code[CHAIN_LEN-1];
            s1_inv   <= ~in_code[NBITS-1:0];
        end
    end

    // S2: partial popcounts over fixed-size groups, last group zero-padded.
    logic [NG*GROUP-1:0] pad_c;
    logic [GW-1:0]       pcnt_c  [NG];
    logic [GW-1:0]       s2_pcnt [NG];
    logic                s2_valid;
    logic                s2_ovf;

    always_comb begin
        pad_c            = '0;
        pad_c[NBITS-1:0] = s1_inv;
        for (int g = 0; g < NG; g++) begin
            pcnt_c[g] = '0;
            for (int b = 0; b < GROUP; b++) begin
                pcnt_c[g] = pcnt_c[g] + GW'(pad_c[g*GROUP+b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_ovf   <= 1'b0;
            for (int g = 0; g < NG; g++) s2_pcnt[g] <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_ovf   <= s1_ovf;
            s2_pcnt  <= pcnt_c;
        end
    end

    // S3 combinational part: group sum, overridden by the chain-end code on overrun.
    logic [OUT_W-1:0] sum_c;
    logic [OUT_W-1:0] fine_c;

    always_comb begin
        sum_c = '0;
        for (int g = 0; g < NG; g++) begin
            sum_c = sum_c + OUT_W'(s2_pcnt[g]);
        end
        fine_c = s2_ovf ? OUT_W'(CHAIN_LEN - 1) : sum_c;
    end

`ifdef TDC_AVG_EN
    localparam int AW = OUT_W + AVG_LOG2;

    logic             s3_valid;
    logic             s3_ovf;
    logic [OUT_W-1:0] s3_fine;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [AVG_LOG2-1:0] cnt;
    logic             ovf_sticky;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s3_valid <= 1'b0;
            s3_ovf   <= 1'b0;
            s3_fine  <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_ovf   <= s2_ovf;
            s3_fine  <= fine_c;
        end
    end

    assign acc_next = acc + AW'(s3_fine);

    // The batch result and the restart of the accumulator share one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_fine   <= '0;
            out_ovf    <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (s3_valid) begin
                if (cnt == '1) begin
                    out_valid  <= 1'b1;
                    out_fine   <= OUT_W'(acc_next >> AVG_LOG2);
                    out_ovf    <= ovf_sticky | s3_ovf;
                    acc        <= '0;
                    cnt        <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= acc_next;
                    cnt        <= cnt + 1'b1;
                    ovf_sticky <= ovf_sticky | s3_ovf;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_fine  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_fine  <= fine_c;
            out_ovf   <= s2_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Self-checking bench for tdc_therm_decoder (default build): directed corner words,
// stall/reset scenarios and randomized traffic scored against a zero-count reference model.
module tb_tdc_therm_decoder;

    localparam int CL = 200;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [CL-1:0] in_code;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_fine;
    logic          out_ovf;

    tdc_therm_decoder #(.CHAIN_LEN(CL), .OUT_W(OW), .AVG_LOG2(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fine  (out_fine),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    bit last_acc = 0;
    bit held_v   = 0;
    logic [OW:0] held;
    logic [OW:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: fine time is the number of zero taps below the chain end; a set end bit means overrun.
    function automatic logic [OW:0] model(input logic [CL-1:0] c);
        logic [CL-2:0] low;
        low = c[CL-2:0];
        if (c[CL-1]) return {1'b1, OW'(CL - 1)};
        return {1'b0, OW'((CL - 1) - $countones(low))};
    endfunction

    function automatic logic [CL-1:0] rand_code();
        logic [CL-1:0] c;
        int k;
        c = '1;
        c[CL-1] = 1'b0;
        k = $urandom_range(0, CL - 1);
        for (int i = 0; i < k; i++) c[i] = 1'b0;
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            k = $urandom_range(0, CL - 2);
            c[k] = ~c[k];
        end
        if ($urandom_range(0, 7) == 0) c[CL-1] = 1'b1;
        return c;
    endfunction

    // One clock: settle, score handshakes seen this cycle, advance to the next negedge.
    task automatic tick();
        logic [OW:0] e;
        #1;
        last_acc = 0;
        if (!rstn) begin
            exp_q.delete();
            held_v = 0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_ovf, out_fine}, held);
            end
            held_v = 0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_code));
                last_acc = 1;
            end
            if (out_valid) begin
                if (out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("out", {out_ovf, out_fine}, e);
                    end
                end else begin
                    held_v = 1;
                    held   = {out_ovf, out_fine};
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [CL-1:0] c);
        in_valid = 1'b1;
        in_code  = c;
        for (int g = 0; g < 50; g++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [CL-1:0] c, input int fine, input int ovf);
        int n;
        out_ready = 1'b1;
        send(c);
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_fine"}, out_fine, fine);
        check({tag, "_ovf"}, out_ovf, ovf);
        tick();
    endtask

    initial begin
        logic [CL-1:0] c;
        logic [CL-1:0] cur;
        int sent;
        int n0;

        rstn = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
        @(negedge clk);
        tick(); tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fine", out_fine, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        c = '1; c[CL-1] = 1'b0; c[36:0] = '0;
        directed("therm37", c, 37, 0);
        c = rand_code(); c[CL-1] = 1'b1;
        directed("overrun", c, CL - 1, 1);
        c = '1; c[CL-1] = 1'b0;
        directed("nostart", c, 0, 0);
        c = '1; c[CL-1] = 1'b0; c[49:0] = '0; c[20] = 1'b1;
        directed("bubble", c, 49, 0);

        // Ten back-to-back words with the sink stalled for cycles 4-7.
        sent = 0;
        n0   = n_out;
        cur  = rand_code();
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (sent < 10);
            in_code   = cur;
            if (cyc == 5) begin
                #1;
                check("stall_in_ready", in_ready, 0);
            end
            tick();
            if (last_acc) begin
                sent++;
                cur = rand_code();
            end
        end
        in_valid = 1'b0;
        check("b2b_count", n_out - n0, 10);

        // Reset with two words in flight.
        out_ready = 1'b1;
        send(rand_code());
        send(rand_code());
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_flush_valid", out_valid, 0);
        c = '1; c[CL-1] = 1'b0; c[99:0] = '0;
        directed("after_rst", c, 100, 0);

        // Random traffic with random backpressure.
        cur = rand_code();
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                cur      = rand_code();
            end
            in_code = cur;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
